uart_tx_arbiter: RTL and testbench

Round-robin arbiter sharing one UART transmitter among `N_REQ` byte-stream requesters. Frame-atomic: a granted requester keeps the transmitter until it sends a byte marked `last` or goes silent for `IDLE_TIMEOUT` cycles. It sits between on-chip producers (command/response engines, debug port) and the single `uart_tx` instance. It sequences that transmitter through its load / `tdre` handshake.

---
 rtl/uart_pkg.sv | 18 +
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding, widths and defaults for the UART transmit arbiter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2
    } uart_arb_state_t;

    localparam int UART_DATA_W       = 8;
    localparam int UART_IDLE_TIMEOUT = 16;

    // Increment modulo n, used to move the round-robin pointer past the last owner.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests by the pointer, take the
// lowest set bit, rotate the winner back to an absolute index.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic                 o_any,
    output logic [N-1:0]         o_onehot,
    output logic [$clog2(N)-1:0] o_idx
);
    localparam int PW = $clog2(N);

    logic [N-1:0] w_rot;
    int           w_sum;

    assign w_rot = N'({i_req, i_req} >> i_ptr);

    always_comb begin
        w_sum = 0;
        for (int i = N - 1; i >= 0; i--)
            if (w_rot[i]) w_sum = i;
        w_sum = w_sum + int'(i_ptr);
        if (w_sum >= N) w_sum = w_sum - N;
    end

    assign o_any    = |i_req;
    assign o_idx    = PW'(w_sum);
    assign o_onehot = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-atomic round-robin arbiter sharing one UART transmitter among N_REQ
// byte-stream requesters, sequencing the transmitter's load / tdre handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int DATA_W       = UART_DATA_W,
    parameter int IDLE_TIMEOUT = UART_IDLE_TIMEOUT
) (
    input  logic                    i_clk,
    input  logic                    i_clr_n,
    input  logic [N_REQ-1:0]        i_req_valid,
    input  logic [N_REQ*DATA_W-1:0] i_req_data,
    input  logic [N_REQ-1:0]        i_req_last,
    output logic [N_REQ-1:0]        o_req_ready,
    output logic [N_REQ-1:0]        o_gnt,
    output logic [DATA_W-1:0]       o_tx_data,
    output logic                    o_tx_load,
    input  logic                    i_tx_tdre,
    output logic                    o_busy,
    output logic                    o_timeout
);
    localparam int PW = $clog2(N_REQ);
    localparam int CW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);

    uart_arb_state_t   r_state, w_state_nxt;
    logic [PW-1:0]     r_g, w_g_nxt;
    logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
    logic [PW-1:0]     r_rr_ptr, w_rr_nxt;
    logic [CW-1:0]     r_idle_cnt, w_cnt_nxt;
    logic              r_last, w_last_nxt;
    logic [DATA_W-1:0] r_tx_data, w_txd_nxt;
    logic              r_tx_load, w_load_nxt;
    logic              r_timeout, w_to_nxt;

    logic              w_pick_any;
    logic [N_REQ-1:0]  w_pick_oh;
    logic [PW-1:0]     w_pick_idx;
    logic [PW-1:0]     w_rr_inc;
    logic              w_cur_valid;
    logic              w_hs;
    logic [DATA_W-1:0] w_bytes [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_bytes
        assign w_bytes[i] = i_req_data[i*DATA_W +: DATA_W];
    end

    rr_pick #(.N(N_REQ)) u_pick (
        .i_req    (i_req_valid),
        .i_ptr    (r_rr_ptr),
        .o_any    (w_pick_any),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx)
    );

    assign w_rr_inc    = PW'(wrap_inc(int'(r_g), N_REQ));
    assign w_cur_valid = i_req_valid[r_g];
    assign w_hs        = (r_state == SEND) && w_cur_valid && i_tx_tdre;

    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr_ptr;
        w_cnt_nxt   = r_idle_cnt;
        w_last_nxt  = r_last;
        w_txd_nxt   = r_tx_data;
        w_load_nxt  = 1'b0;
        w_to_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = SEND;
                    w_g_nxt     = w_pick_idx;
                    w_gnt_nxt   = w_pick_oh;
                    w_cnt_nxt   = '0;
                end
            end
            SEND: begin
                if (w_hs) begin
                    w_state_nxt = BUSY;
                    w_txd_nxt   = w_bytes[r_g];
                    w_load_nxt  = 1'b1;
                    w_last_nxt  = i_req_last[r_g];
                    w_cnt_nxt   = '0;
                end else if (!w_cur_valid) begin
                    // Silence counts only while the owner has nothing to offer;
                    // a stalled transmitter never revokes the grant.
                    if (r_idle_cnt == CNT_LAST) begin
                        w_state_nxt = IDLE;
                        w_to_nxt    = 1'b1;
                        w_gnt_nxt   = '0;
                        w_rr_nxt    = w_rr_inc;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_idle_cnt + 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!i_tx_tdre) begin
                    if (r_last) begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_rr_nxt    = w_rr_inc;
                    end else begin
                        w_state_nxt = SEND;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clr_n) begin
        if (!i_clr_n) begin
            r_state    <= IDLE;
            r_g        <= '0;
            r_gnt      <= '0;
            r_rr_ptr   <= '0;
            r_idle_cnt <= '0;
            r_last     <= 1'b0;
            r_tx_data  <= '0;
            r_tx_load  <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_g        <= w_g_nxt;
            r_gnt      <= w_gnt_nxt;
            r_rr_ptr   <= w_rr_nxt;
            r_idle_cnt <= w_cnt_nxt;
            r_last     <= w_last_nxt;
            r_tx_data  <= w_txd_nxt;
            r_tx_load  <= w_load_nxt;
            r_timeout  <= w_to_nxt;
        end
    end

    assign o_req_ready = w_hs ? r_gnt : '0;
    assign o_gnt       = r_gnt;
    assign o_tx_data   = r_tx_data;
    assign o_tx_load   = r_tx_load;
    assign o_busy      = (r_state != IDLE);
    assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a cycle table plus multi-cycle sequences
// against a transmitter model that holds tdre low for 10 cycles after each load.
module tb_uart_tx_arbiter;

    logic        clk, clr_n;
    logic [3:0]  valid, last, ready, gnt;
    logic [31:0] data;
    logic [7:0]  txd;
    logic        load, tdre, busy, timeout;
    logic        model_en, tdre_v;
    int          m_cnt;
    logic [7:0]  loads [$];
    int          total, bad;

    logic [8:0]  qm [4][8];
    int          qh [4];
    int          qt [4];
    int          log_w, log_n, to_cnt, multi, hs;
    logic        late_en, late_done;

    uart_tx_arbiter #(.N_REQ(4), .DATA_W(8), .IDLE_TIMEOUT(16)) dut (
        .i_clk       (clk),
        .i_clr_n     (clr_n),
        .i_req_valid (valid),
        .i_req_data  (data),
        .i_req_last  (last),
        .o_req_ready (ready),
        .o_gnt       (gnt),
        .o_tx_data   (txd),
        .o_tx_load   (load),
        .i_tx_tdre   (tdre),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge clr_n) begin
        if (!clr_n) m_cnt <= 0;
        else if (load) begin
            m_cnt <= 10;
            loads.push_back(txd);
        end else if (m_cnt != 0) m_cnt <= m_cnt - 1;
    end

    assign tdre = model_en ? (m_cnt == 0) : tdre_v;

    typedef struct packed {
        logic [3:0] v;
        logic [3:0] l;
        logic       t;
        logic [3:0] rdy;
        logic [3:0] g;
        logic       ld;
        logic [7:0] d;
        logic       b;
        logic       to;
    } vec_t;
    vec_t tbl [19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        clr_n = 1'b0;
        valid = '0;
        last  = '0;
        repeat (2) @(posedge clk);
        #1 clr_n = 1'b1;
    endtask

    task automatic clear_q();
        for (int i = 0; i < 4; i++) begin
            qh[i] = 0;
            qt[i] = 0;
        end
        log_w = 0; log_n = 0; to_cnt = 0; multi = 0; hs = 0;
        late_en = 1'b0; late_done = 1'b0;
        loads.delete();
    endtask

    task automatic push(input int r, input logic [7:0] b, input logic l);
        qm[r][qt[r]] = {l, b};
        qt[r]++;
    endtask

    task automatic drive_q();
        for (int i = 0; i < 4; i++) begin
            if (qh[i] != qt[i]) begin
                valid[i]       = 1'b1;
                data[i*8 +: 8] = qm[i][qh[i]][7:0];
                last[i]        = qm[i][qh[i]][8];
            end else begin
                valid[i] = 1'b0;
                last[i]  = 1'b0;
            end
        end
    endtask

    // Each requester offers its queued bytes; handshakes are logged as a nibble stream.
    task automatic run_engine(input string nm, input int budget);
        logic fin;
        fin = 1'b0;
        for (int c = 0; c < budget; c++) begin
            if (qh[0] == qt[0] && qh[1] == qt[1] && qh[2] == qt[2] && qh[3] == qt[3]) begin
                fin = 1'b1;
                break;
            end
            drive_q();
            @(negedge clk);
            if ($countones(ready) > 1) multi++;
            if (timeout) to_cnt++;
            for (int i = 0; i < 4; i++)
                if (ready[i]) begin
                    log_w = (log_w << 4) | i;
                    log_n++;
                    qh[i]++;
                    hs++;
                end
            if (late_en && !late_done && hs == 2) begin
                push(3, 8'h7F, 1'b1);
                late_done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        valid = '0;
        last  = '0;
        chk({nm, " drained"}, 32'(fin), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!busy) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({nm, " idle reached"}, 32'(hit), 32'd1);
    endtask

    task automatic wait_ready(input string nm, input int r);
        logic hit;
        hit = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (ready[r]) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk({nm, " handshake"}, 32'(hit), 32'd1);
    endtask

    function automatic logic [7:0] ld_at(input int i);
        return (loads.size() > i) ? loads[i] : 8'hxx;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        clr_n = 1'b0; valid = '0; last = '0; data = '0;
        model_en = 1'b0; tdre_v = 1'b1;
        clear_q();

        // v     l     t     rdy   g     ld    d      b     to
        tbl[0]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[1]  = '{4'b0010, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'h00, 1'b0, 1'b0};
        tbl[2]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[3]  = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0010, 1'b1, 8'hB1, 1'b1, 1'b0};
        tbl[4]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 8'hB1, 1'b1, 1'b0};
        tbl[5]  = '{4'b1011, 4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'hB1, 1'b0, 1'b0};
        tbl[6]  = '{4'b1011, 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b0, 8'hB1, 1'b1, 1'b0};
        tbl[7]  = '{4'b1011, 4'b1111, 1'b1, 4'b1000, 4'b1000, 1'b0, 8'hB1, 1'b1, 1'b0};
        tbl[8]  = '{4'b1011, 4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b1, 8'hD3, 1'b1, 1'b0};
        tbl[9]  = '{4'b1011, 4'b1111, 1'b0, 4'b0000, 4'b1000, 1'b0, 8'hD3, 1'b1, 1'b0};
        tbl[10] = '{4'b1011, 4'b1111, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hD3, 1'b0, 1'b0};
        tbl[11] = '{4'b1011, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b0, 8'hD3, 1'b1, 1'b0};
        tbl[12] = '{4'b1011, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b1, 8'hA0, 1'b1, 1'b0};
        tbl[13] = '{4'b1011, 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 8'hA0, 1'b1, 1'b0};
        tbl[14] = '{4'b1010, 4'b0001, 1'b1, 4'b0000, 4'b0001, 1'b0, 8'hA0, 1'b1, 1'b0};
        tbl[15] = '{4'b1011, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b0, 8'hA0, 1'b1, 1'b0};
        tbl[16] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, 1'b1, 8'hA0, 1'b1, 1'b0};
        tbl[17] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0001, 1'b0, 8'hA0, 1'b1, 1'b0};
        tbl[18] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 8'hA0, 1'b0, 1'b0};

        do_reset();
        @(negedge clk);
        chk("reset rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
        chk("reset idle_cnt", 32'(dut.r_idle_cnt), 32'd0);
        @(posedge clk);
        #1;

        // Cycle table, transmitter tdre driven directly.
        data = 32'hD3C2B1A0;
        for (int i = 0; i < 19; i++) begin
            valid  = tbl[i].v;
            last   = tbl[i].l;
            tdre_v = tbl[i].t;
            @(negedge clk);
            chk($sformatf("row%0d ready", i), 32'(ready), 32'(tbl[i].rdy));
            chk($sformatf("row%0d gnt", i), 32'(gnt), 32'(tbl[i].g));
            chk($sformatf("row%0d load", i), 32'(load), 32'(tbl[i].ld));
            chk($sformatf("row%0d txd", i), 32'(txd), 32'(tbl[i].d));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(tbl[i].b));
            chk($sformatf("row%0d timeout", i), 32'(timeout), 32'(tbl[i].to));
            @(posedge clk);
            #1;
        end
        chk("table rr_ptr", 32'(dut.r_rr_ptr), 32'd1);

        // A: single requester, three-byte frame.
        model_en = 1'b1;
        do_reset();
        clear_q();
        push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b0); push(0, 8'h43, 1'b1);
        run_engine("A", 200);
        wait_idle("A");
        chk("A load count", 32'(loads.size()), 32'd3);
        chk("A byte0", 32'(ld_at(0)), 32'h41);
        chk("A byte1", 32'(ld_at(1)), 32'h42);
        chk("A byte2", 32'(ld_at(2)), 32'h43);
        chk("A gnt released", 32'(gnt), 32'd0);
        chk("A rr_ptr", 32'(dut.r_rr_ptr), 32'd1);
        chk("A timeouts", 32'(to_cnt), 32'd0);

        // B: all four requesting from reset, one-byte frames; requester 0 has two.
        do_reset();
        clear_q();
        push(0, 8'h50, 1'b1); push(0, 8'h54, 1'b1);
        push(1, 8'h51, 1'b1); push(2, 8'h52, 1'b1); push(3, 8'h53, 1'b1);
        run_engine("B", 400);
        wait_idle("B");
        chk("B order", 32'(log_w), 32'h01230);
        chk("B count", 32'(log_n), 32'd5);
        chk("B multi ready", 32'(multi), 32'd0);
        chk("B byte0", 32'(ld_at(0)), 32'h50);
        chk("B byte1", 32'(ld_at(1)), 32'h51);
        chk("B byte2", 32'(ld_at(2)), 32'h52);
        chk("B byte3", 32'(ld_at(3)), 32'h53);
        chk("B byte4", 32'(ld_at(4)), 32'h54);

        // D: requester 3 arrives while requester 0 streams a five-byte frame.
        do_reset();
        clear_q();
        for (int i = 0; i < 5; i++) push(0, 8'(8'h70 + i), (i == 4));
        late_en = 1'b1;
        run_engine("D", 400);
        wait_idle("D");
        chk("D order", 32'(log_w), 32'h000003);
        chk("D count", 32'(log_n), 32'd6);
        chk("D byte4", 32'(ld_at(4)), 32'h74);
        chk("D byte5", 32'(ld_at(5)), 32'h7F);

        // C: owner goes silent mid-frame; requester 2 waits for the timeout.
        do_reset();
        clear_q();
        begin
            logic hit;
            int   n;
            valid = 4'b0010; last = 4'b0000; data[15:8] = 8'h61;
            wait_ready("C", 1);
            @(posedge clk);
            #1;
            valid = 4'b0100; last = 4'b0100; data[23:16] = 8'h62;
            hit = 1'b0;
            n   = 0;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                if (timeout) begin
                    hit = 1'b1;
                    break;
                end
                if (busy) n++;
                @(posedge clk);
                #1;
            end
            chk("C timeout seen", 32'(hit), 32'd1);
            // two BUSY cycles for the loaded byte, then 16 silent SEND cycles
            chk("C held cycles", 32'(n), 32'd18);
            chk("C gnt at timeout", 32'(gnt), 32'd0);
            chk("C rr_ptr", 32'(dut.r_rr_ptr), 32'd2);
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("C timeout pulse width", 32'(timeout), 32'd0);
            chk("C gnt r2", 32'(gnt), 32'b0100);
            chk("C ready r2", 32'(ready), 32'b0100);
            @(posedge clk);
            #1;
            valid = '0; last = '0;
        end

        // E: reset during BUSY, then arbitration restarts at requester 0.
        do_reset();
        clear_q();
        valid = 4'b0010; last = 4'b0010; data[15:8] = 8'h81;
        wait_ready("E r1", 1);
        @(posedge clk);
        #1;
        valid = '0; last = '0;
        wait_idle("E");
        @(posedge clk);
        #1;
        valid = 4'b0100; last = 4'b0000; data[23:16] = 8'h82;
        wait_ready("E r2", 2);
        @(posedge clk);
        #1;
        chk("E load before reset", 32'(load), 32'd1);
        #1 clr_n = 1'b0;
        #1;
        chk("E rst gnt", 32'(gnt), 32'd0);
        chk("E rst load", 32'(load), 32'd0);
        chk("E rst txd", 32'(txd), 32'd0);
        chk("E rst busy", 32'(busy), 32'd0);
        chk("E rst ready", 32'(ready), 32'd0);
        chk("E rst timeout", 32'(timeout), 32'd0);
        chk("E rst rr_ptr", 32'(dut.r_rr_ptr), 32'd0);
        valid = 4'b1111; last = 4'b1111;
        @(negedge clk);
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("E restart gnt", 32'(gnt), 32'b0001);
        @(posedge clk);
        #1;
        valid = '0; last = '0;

        // F: transmitter stalled with the owner valid; nothing moves, nothing times out.
        do_reset();
        model_en = 1'b0;
        tdre_v   = 1'b0;
        valid = 4'b0001; last = 4'b0000;
        begin
            int rc, tc;
            rc = 0;
            tc = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (ready != 0) rc++;
                if (timeout) tc++;
                @(posedge clk);
                #1;
            end
            chk("F ready cycles", 32'(rc), 32'd0);
            chk("F timeouts", 32'(tc), 32'd0);
        end
        chk("F gnt held", 32'(gnt), 32'b0001);
        chk("F idle_cnt", 32'(dut.r_idle_cnt), 32'd0);
        tdre_v = 1'b1;
        @(negedge clk);
        chk("F ready after tdre", 32'(ready), 32'b0001);
        @(posedge clk);
        #1;
        valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
